// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction fetch controller
// Contents: sequencer state enum, fault cause codes, default boot PC,
//           and the address legality check shared by loader and fetch paths.
package imem_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_RANGE    = 2'b10;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Misalignment is reported ahead of range so a bad low-order pair wins.
    function automatic logic [1:0] addr_fault(input logic [31:0] addr, input int unsigned addr_w);
        logic [31:0] hi;
        hi = addr >> (addr_w + 2);
        if (addr[1:0] != 2'b00) begin
            return FC_MISALIGN;
        end else if (hi != 32'd0) begin
            return FC_RANGE;
        end
        return FC_NONE;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - two-entry {pc, instr} buffer: output register plus skid
// Ports: clk, rst_n (sync, active-low), flush_i;
//        in_tvalid_i/in_pc_i/in_tdata_i  push side (caller never overfills);
//        out_tvalid_o/out_tready_i/out_pc_o/out_tdata_o  registered head;
//        count_o  number of held entries (0..2).
import imem_pkg::*;

module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        in_tvalid_i,
    input  logic [31:0] in_pc_i,
    input  logic [31:0] in_tdata_i,
    output logic        out_tvalid_o,
    input  logic        out_tready_i,
    output logic [31:0] out_pc_o,
    output logic [31:0] out_tdata_o,
    output logic [1:0]  count_o
);

    logic        head_v_q, head_v_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] head_data_q, head_data_d;
    logic        skid_v_q, skid_v_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_data_q, skid_data_d;

    always_comb begin
        head_v_d    = head_v_q;
        head_pc_d   = head_pc_q;
        head_data_d = head_data_q;
        skid_v_d    = skid_v_q;
        skid_pc_d   = skid_pc_q;
        skid_data_d = skid_data_q;
        if (flush_i) begin
            // Payload is kept; only the valid bits are dropped.
            head_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else begin
            if (head_v_q && out_tready_i) begin
                head_v_d    = skid_v_q;
                head_pc_d   = skid_pc_q;
                head_data_d = skid_data_q;
                skid_v_d    = 1'b0;
            end
            // Push goes to the head if the pop above emptied it, else to the skid.
            if (in_tvalid_i) begin
                if (!head_v_d) begin
                    head_v_d    = 1'b1;
                    head_pc_d   = in_pc_i;
                    head_data_d = in_tdata_i;
                end else begin
                    skid_v_d    = 1'b1;
                    skid_pc_d   = in_pc_i;
                    skid_data_d = in_tdata_i;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_v_q    <= 1'b0;
            head_pc_q   <= 32'd0;
            head_data_q <= 32'd0;
            skid_v_q    <= 1'b0;
            skid_pc_q   <= 32'd0;
            skid_data_q <= 32'd0;
        end else begin
            head_v_q    <= head_v_d;
            head_pc_q   <= head_pc_d;
            head_data_q <= head_data_d;
            skid_v_q    <= skid_v_d;
            skid_pc_q   <= skid_pc_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign out_tvalid_o = head_v_q;
    assign out_pc_o     = head_pc_q;
    assign out_tdata_o  = head_data_q;
    assign count_o      = {1'b0, head_v_q} + {1'b0, skid_v_q};

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction memory port owner: boot loader writes, then PC-driven fetch
// Ports: clk, rst_n (sync, active-low);
//        ld_*        loader write port (BOOT only), ld_err pulses on a dropped write;
//        redirect_*  branch/jump redirect (RUN only);
//        if_*        fetched word towards IF/ID with valid/ready;
//        mem_*       single-port word-addressed memory, read data one cycle after a read;
//        fault/fault_cause  sticky address fault.
import imem_pkg::*;

module imem_fetch_ctrl #(
    parameter int unsigned ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_data,
    input  logic              ld_done,
    output logic              ld_err,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_instr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              fault,
    output logic [1:0]        fault_cause
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        infl_q, infl_d;        // a read was issued last cycle; its data is on mem_rdata now
    logic [31:0] infl_pc_q, infl_pc_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;
    logic        ld_err_q, ld_err_d;

    logic [1:0]  buf_count;
    logic        pop;
    logic [2:0]  occ_after_pop;
    logic [1:0]  ld_fc, pc_fc;
    logic        in_boot, in_run;
    logic        ld_write, want_issue, issue, flush;

    assign in_boot = (state_q == ST_BOOT);
    assign in_run  = (state_q == ST_RUN);
    assign ld_fc   = addr_fault(ld_addr, ADDR_W);
    assign pc_fc   = addr_fault(pc_q, ADDR_W);
    assign pop     = if_valid && if_ready;

    // At most one read is ever in flight, so in-flight plus buffered never exceeds 2.
    assign occ_after_pop = {2'b00, infl_q} + {1'b0, buf_count} - {2'b00, pop};

    assign ld_write   = rst_n && in_boot && ld_valid && (ld_fc == FC_NONE);
    assign want_issue = in_run && !redirect_valid && (occ_after_pop < 3'd2);
    assign issue      = rst_n && want_issue && (pc_fc == FC_NONE);
    assign flush      = in_run && redirect_valid;

    assign ld_ready = in_boot;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        if (ld_write) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ld_addr[ADDR_W+1:2];
            mem_wdata = ld_data;
        end else if (issue) begin
            mem_en   = 1'b1;
            mem_addr = pc_q[ADDR_W+1:2];
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        infl_d    = 1'b0;
        infl_pc_d = infl_pc_q;
        fault_d   = fault_q;
        cause_d   = cause_q;
        ld_err_d  = 1'b0;
        case (state_q)
            ST_BOOT: begin
                ld_err_d = ld_valid && (ld_fc != FC_NONE);
                // A write in the same cycle as ld_done has already gone out combinationally.
                if (ld_done) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (want_issue) begin
                    if (pc_fc != FC_NONE) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                        cause_d = pc_fc;
                    end else begin
                        infl_d    = 1'b1;
                        infl_pc_d = pc_q;
                        pc_d      = pc_q + 32'd4;
                    end
                end
            end
            default: begin
                // FAULT holds until reset; in-flight and buffered words still drain.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            infl_q    <= 1'b0;
            infl_pc_q <= 32'd0;
            fault_q   <= 1'b0;
            cause_q   <= FC_NONE;
            ld_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
            fault_q   <= fault_d;
            cause_q   <= cause_d;
            ld_err_q  <= ld_err_d;
        end
    end

    // The returning word is discarded on redirect because flush wins inside the buffer.
    fetch_skid_buf u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush),
        .in_tvalid_i  (infl_q),
        .in_pc_i      (infl_pc_q),
        .in_tdata_i   (mem_rdata),
        .out_tvalid_o (if_valid),
        .out_tready_i (if_ready),
        .out_pc_o     (if_pc),
        .out_tdata_o  (if_instr),
        .count_o      (buf_count)
    );

    assign fault       = fault_q;
    assign fault_cause = cause_q;
    assign ld_err      = ld_err_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - self-checking bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;

    localparam int unsigned ADDR_W = 8;
    localparam int          M_BOOT = 0, M_RUN = 1, M_FAULT = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [31:0]       ld_addr = 32'd0;
    logic [31:0]       ld_data = 32'd0;
    logic              ld_done = 1'b0;
    logic              ld_err;
    logic              redirect_valid = 1'b0;
    logic [31:0]       redirect_pc = 32'd0;
    logic              if_valid;
    logic              if_ready = 1'b0;
    logic [31:0]       if_pc;
    logic [31:0]       if_instr;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              fault;
    logic [1:0]        fault_cause;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_done(ld_done), .ld_err(ld_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .fault(fault), .fault_cause(fault_cause)
    );

    // External memory: preloaded with 0xA000_0000 + word index.
    logic [31:0] ram [256];
    logic        ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'hA000_0000 + i;
            ram_init <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Model: a queue of fetched pcs each tagged with the cycle it becomes visible.
    typedef struct {
        logic [31:0] pc;
        int          avail;
    } ent_t;

    ent_t        q[$];
    logic [31:0] gold [256];
    logic        gold_init = 1'b0;
    int          cyc = 0;
    int          m_state = M_BOOT;
    logic [31:0] m_pc = 32'd0;
    logic        m_fault = 1'b0;
    logic [1:0]  m_cause = 2'd0;
    logic        m_lderr = 1'b0;

    always @(negedge clk) begin
        logic        exp_valid, pop, e_en, e_we, nlderr;
        logic [31:0] e_addr, e_wd;
        logic [7:0]  idx;
        ent_t        e;
        cyc++;
        if (!gold_init) begin
            for (int i = 0; i < 256; i++) gold[i] = 32'hA000_0000 + i;
            gold_init = 1'b1;
        end
        if (!rst_n) begin
            q.delete();
            m_state = M_BOOT;
            m_pc    = 32'd0;
            m_fault = 1'b0;
            m_cause = 2'd0;
            m_lderr = 1'b0;
        end else begin
            exp_valid = (q.size() > 0) && (q[0].avail <= cyc);
            chk("m_if_valid", if_valid, exp_valid);
            if (exp_valid) begin
                idx = q[0].pc[9:2];
                chk("m_if_pc", if_pc, q[0].pc);
                chk("m_if_instr", if_instr, gold[idx]);
            end
            chk("m_fault", fault, m_fault);
            chk("m_cause", fault_cause, m_cause);
            chk("m_ld_err", ld_err, m_lderr);
            chk("m_ld_ready", ld_ready, m_state == M_BOOT);
            pop    = exp_valid && if_ready;
            e_en   = 1'b0;
            e_we   = 1'b0;
            e_addr = 32'd0;
            e_wd   = 32'd0;
            nlderr = 1'b0;
            if (m_state == M_BOOT) begin
                if (ld_valid) begin
                    if ((ld_addr % 4 == 0) && (ld_addr < 32'd1024)) begin
                        e_en = 1'b1;
                        e_we = 1'b1;
                        e_addr = ld_addr / 4;
                        e_wd = ld_data;
                        idx = ld_addr[9:2];
                        gold[idx] = ld_data;
                    end else begin
                        nlderr = 1'b1;
                    end
                end
                if (ld_done) begin
                    m_state = M_RUN;
                    m_pc    = 32'd0;
                end
            end else if (m_state == M_RUN) begin
                if (pop) void'(q.pop_front());
                if (redirect_valid) begin
                    q.delete();
                    m_pc = redirect_pc;
                end else if (q.size() < 2) begin
                    if (m_pc % 4 != 0) begin
                        m_state = M_FAULT; m_fault = 1'b1; m_cause = 2'd1;
                    end else if (m_pc >= 32'd1024) begin
                        m_state = M_FAULT; m_fault = 1'b1; m_cause = 2'd2;
                    end else begin
                        e_en   = 1'b1;
                        e_addr = m_pc / 4;
                        e.pc    = m_pc;
                        e.avail = cyc + 2;
                        q.push_back(e);
                        m_pc = m_pc + 32'd4;
                    end
                end
            end else begin
                if (pop) void'(q.pop_front());
            end
            chk("m_mem_en", mem_en, e_en);
            if (e_en) begin
                chk("m_mem_we", mem_we, e_we);
                chk("m_mem_addr", {24'd0, mem_addr}, e_addr);
                if (e_we) chk("m_mem_wdata", mem_wdata, e_wd);
            end
            m_lderr = nlderr;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #2;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d, input logic good);
        ld_valid = 1'b1; ld_addr = a; ld_data = d;
        mid();
        chk("ld_mem_en", mem_en, good);
        if (good) begin
            chk("ld_mem_we", mem_we, 1'b1);
            chk("ld_mem_addr", {24'd0, mem_addr}, a >> 2);
            chk("ld_mem_wdata", mem_wdata, d);
        end
        nxt();
        ld_valid = 1'b0;
        mid();
        chk("ld_err_pulse", ld_err, !good);
        nxt();
    endtask

    initial begin
        nxt(); nxt();
        rst_n = 1'b1;
        mid();
        chk("rst_if_valid", if_valid, 1'b0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_ld_ready", ld_ready, 1'b1);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_cause", fault_cause, 2'd0);
        chk("rst_ld_err", ld_err, 1'b0);
        nxt();

        load(32'h0, 32'h2008_0005, 1'b1);
        load(32'h4, 32'h2009_0006, 1'b1);
        load(32'h8, 32'h200A_0007, 1'b1);
        load(32'hC, 32'h200B_0008, 1'b1);
        load(32'h6, 32'hDEAD_BEEF, 1'b0);
        load(32'h400, 32'hCAFE_F00D, 1'b0);
        chk("ram0_kept", ram[0], 32'h2008_0005);
        chk("ram1_kept", ram[1], 32'h2009_0006);

        redirect_valid = 1'b1; redirect_pc = 32'h80;
        mid();
        chk("boot_redir_ign", mem_en, 1'b0);
        nxt();
        redirect_valid = 1'b0;

        ld_done = 1'b1; if_ready = 1'b1;
        mid();
        nxt();
        ld_done = 1'b0;
        mid();
        chk("d1_valid", if_valid, 1'b0);
        chk("d1_issue", mem_en, 1'b1);
        chk("d1_addr", {24'd0, mem_addr}, 32'd0);
        nxt();
        mid();
        chk("d2_valid", if_valid, 1'b0);
        nxt();
        for (int k = 0; k < 10; k++) begin
            mid();
            chk("stream_valid", if_valid, 1'b1);
            chk("stream_pc", if_pc, 4 * k);
            nxt();
        end
        chk("stream_instr3", ram[3], 32'h200B_0008);

        if_ready = 1'b0;
        for (int h = 0; h < 5; h++) begin
            mid();
            chk("hold_valid", if_valid, 1'b1);
            chk("hold_pc", if_pc, 32'h28);
            chk("hold_no_issue", mem_en, 1'b0);
            nxt();
        end
        if_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("resume_pc", if_pc, 32'h28 + 4 * k);
            nxt();
        end

        if_ready = 1'b0;
        nxt(); nxt(); nxt();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        mid();
        chk("r0_valid", if_valid, 1'b1);
        chk("r0_no_issue", mem_en, 1'b0);
        nxt();
        redirect_valid = 1'b0; if_ready = 1'b1;
        mid();
        chk("r1_valid", if_valid, 1'b0);
        chk("r1_issue", mem_en, 1'b1);
        chk("r1_addr", {24'd0, mem_addr}, 32'h10);
        nxt();
        mid();
        chk("r2_valid", if_valid, 1'b0);
        nxt();
        mid();
        chk("r3_valid", if_valid, 1'b1);
        chk("r3_pc", if_pc, 32'h40);
        chk("r3_instr", if_instr, 32'hA000_0010);
        nxt(); nxt(); nxt(); nxt();

        redirect_valid = 1'b1; redirect_pc = 32'h42;
        mid();
        nxt();
        redirect_valid = 1'b0;
        mid();
        chk("mis_no_issue", mem_en, 1'b0);
        chk("mis_fault_pre", fault, 1'b0);
        nxt();
        mid();
        chk("mis_fault", fault, 1'b1);
        chk("mis_cause", fault_cause, 2'd1);
        chk("mis_valid", if_valid, 1'b0);
        nxt();
        for (int h = 0; h < 3; h++) begin
            mid();
            chk("fault_no_issue", mem_en, 1'b0);
            nxt();
        end

        rst_n = 1'b0;
        nxt();
        rst_n = 1'b1;
        mid();
        chk("rst2_ld_ready", ld_ready, 1'b1);
        chk("rst2_fault", fault, 1'b0);
        chk("rst2_cause", fault_cause, 2'd0);
        chk("rst2_valid", if_valid, 1'b0);
        nxt();

        ld_valid = 1'b1; ld_addr = 32'h3F8; ld_data = 32'h1234_5678; ld_done = 1'b1;
        mid();
        chk("done_wr_en", mem_en, 1'b1);
        chk("done_wr_we", mem_we, 1'b1);
        chk("done_wr_addr", {24'd0, mem_addr}, 32'hFE);
        nxt();
        ld_valid = 1'b0; ld_done = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h3F0;
        mid();
        chk("end_redir_no_issue", mem_en, 1'b0);
        nxt();
        redirect_valid = 1'b0;
        nxt(); nxt();
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("end_valid", if_valid, 1'b1);
            chk("end_pc", if_pc, 32'h3F0 + 4 * k);
            chk("end_issue", mem_en, k < 2);
            chk("end_fault", fault, k == 3);
            if (k == 2) chk("end_instr_ld", if_instr, 32'h1234_5678);
            nxt();
        end
        mid();
        chk("end_instr_last", ram[255], 32'hA000_00FF);
        chk("end_cause", fault_cause, 2'd2);
        chk("end_drained", if_valid, 1'b0);
        nxt();

        rst_n = 1'b0;
        nxt();
        rst_n = 1'b1;
        mid();
        chk("rst3_ld_ready", ld_ready, 1'b1);
        chk("rst3_fault", fault, 1'b0);
        chk("rst3_valid", if_valid, 1'b0);
        nxt(); nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Sequencer and arbiter for the single-port, word-addressed instruction memory. It owns the memory port and shares it between a boot-time program loader (writes) and the fetch stage (reads). During fetch it maintains the PC, issues one read per cycle, and buffers returned words behind a valid/ready handshake. It also handles branch redirects, flushes the buffer on redirect, and halts on an address fault. It sits between the loader/debug port, the instruction memory and the IF/ID pipeline register.

## Interface
Parameters:
- ADDR_W, 8: memory word-index width; depth is 2^ADDR_W words.
- RESET_PC, 32'h0000_0000: first fetch address after boot.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ld_valid  in  1  loader write request.
- ld_ready  out  1  loader write accepted.
- ld_addr  in  32  loader byte address.
- ld_data  in  32  loader write word.
- ld_done  in  1  end-of-boot strobe.
- ld_err  out  1  one-cycle pulse when a loader write is dropped.
- redirect_valid  in  1  branch/jump redirect.
- redirect_pc  in  32  redirect byte address.
- if_valid  out  1  instruction available.
- if_ready  in  1  pipeline accepts the instruction.
- if_pc  out  32  byte address of if_instr.
- if_instr  out  32  fetched word.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  write (1) or read (0).
- mem_addr  out  ADDR_W  word index.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid the cycle after a read.
- fault  out  1  sticky fault flag.
- fault_cause  out  2  01 misaligned, 10 out of range.

## Operation
- States are BOOT, RUN and FAULT. Reset enters BOOT.
- BOOT:
  - ld_ready=1.
  - On ld_valid, drive mem_en=1, mem_we=1, mem_addr=ld_addr[ADDR_W+1:2], mem_wdata=ld_data in the same cycle.
  - If ld_addr[1:0]!=0 or ld_addr[31:ADDR_W+2]!=0, the write is dropped (mem_en=0) and ld_err pulses.
  - ld_done moves to RUN on the next edge, with pc<=RESET_PC.
  - ld_done together with ld_valid: the write completes first.
  - redirect_valid is ignored in BOOT.
- RUN:
  - ld_ready=0.
  - Occupancy = reads in flight + buffered words, capped at 2; the buffer is 2 entries (output register plus skid).
  - Issue a read (mem_en=1, mem_we=0, mem_addr=pc[ADDR_W+1:2]) when projected occupancy after this cycle's pop is below 2. Then pc<=pc+4.
  - Returned words are tagged with their pc and land in the buffer in order. if_valid is high when the buffer is non-empty. A word is popped on if_valid&&if_ready.
  - Held if_ready=0 stops issue after 2 words are outstanding. No word is lost and none is duplicated.
- Redirect (RUN):
  - Drop all in-flight and buffered words.
  - pc<=redirect_pc.
  - if_valid=0 on the next cycle.
  - No issue occurs in the redirect cycle.
  - Redirect wins over a simultaneous pop or issue.
- Fault:
  - Checked on the pc about to be issued: misaligned gives 01, out of range gives 10, misaligned takes priority.
  - Go to FAULT with no issue. Set fault/fault_cause. Already-buffered words still drain.
  - FAULT is left only by reset.
  - This includes pc incrementing past the last word (wrap-around is a fault, not a wrap) and a redirect to a bad address.

## Timing
- Reset values:
  - State BOOT, pc=RESET_PC.
  - if_valid=0, if_pc=0, if_instr=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - ld_ready=1, ld_err=0, fault=0, fault_cause=0.
- Reset asserted mid-operation takes effect at the next edge and discards buffered words.
- ld_ready and mem_* are combinational from state and inputs. if_valid, if_pc, if_instr, fault and ld_err are registered.
- Loader write: 0 cycles (same cycle as ld_valid).
- Fetch latency is 2 cycles: issue at N, mem_rdata at N+1, if_valid at N+2.
- With if_ready=1 the steady-state throughput is 1 instruction/cycle.
- First if_valid after ld_done is 3 cycles later: RUN at +1, issue +1, data +2, valid +3.
- Redirect at cycle R: first issue at R+1, if_valid for redirect_pc at R+3.

## Structure
- Shared package `imem_pkg`:
  - State enum.
  - Fault cause constants FC_NONE/FC_MISALIGN/FC_RANGE.
  - RESET_PC default.
- Optional sub-module `fetch_skid_buf`: 2-entry {pc, instr} buffer with valid/ready and flush.
- Instantiate the memory outside this block.

## Test plan
- Boot load: 4 writes to 0x0,0x4,0x8,0xC (values 0x20080005...) then ld_done -> mem writes seen 1:1; ld_err never pulses; if_valid at ld_done+3 with if_pc=0x0.
- Bad load: ld_addr=0x6 and ld_addr=0x400 (ADDR_W=8) -> mem_en=0 and ld_err pulses each time; the memory is unchanged.
- Streaming: if_ready=1 for 10 cycles -> if_pc 0x0,0x4,... on consecutive cycles, matching memory contents.
- Backpressure: drop if_ready for 5 cycles mid-stream -> at most 2 outstanding; the sequence resumes with no gap or duplicate.
- Redirect to 0x40 while 2 words buffered -> if_valid=0 next cycle; next delivered if_pc=0x40 at R+3. Redirect to 0x42 -> fault=1, cause=01, no further issue.
- Run off end: pc reaches 0x3FC then increments -> word 0x3FC delivered, then fault cause=10. Reset then returns to BOOT with ld_ready=1.
